imm_seq: RTL and testbench

IMM_SEQ -- requirements
Module: imm_seq

---
 rtl/imm_seq_pkg.sv | 38 +++
 rtl/imm_extend.sv | 38 +++
 rtl/imm_seq.sv | 107 ++++++++++
 tb/tb_imm_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/imm_seq_pkg.sv
// imm_seq_pkg: shared definitions for the immediate generator.
//   kind_e  - extender control encodings, also reported on out_kind
//   OP_*    - opcode match constants used by the decoder
//   fifo_st_e - occupancy states of the two-entry output buffer
//   entry_t - one buffered result (immediate, kind, error flag)
package imm_seq_pkg;

  typedef enum logic [2:0] {
    K_I   = 3'd0,
    K_D   = 3'd1,
    K_B   = 3'd2,
    K_CB  = 3'd3,
    K_IW  = 3'd4,
    K_ILL = 3'd7
  } kind_e;

  // Opcode fields, matched against the top bits of the instruction word
  localparam logic [5:0]  OP_B     = 6'b000101;       // instr[31:26]
  localparam logic [6:0]  OP_CB    = 7'b1011010;      // instr[31:25]
  localparam logic [10:0] OP_LDUR  = 11'b11111000010; // instr[31:21]
  localparam logic [10:0] OP_STUR  = 11'b11111000000; // instr[31:21]
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;  // instr[31:22]
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;  // instr[31:22]
  localparam logic [8:0]  OP_MOVZ  = 9'b110100101;    // instr[31:23]

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } fifo_st_e;

  typedef struct packed {
    logic [63:0] imm;
    kind_e       kind;
    logic        err;
  } entry_t;

endpackage

// File: rtl/imm_extend.sv
// imm_extend: combinational immediate former.
//   instr - low 26 bits of the instruction word (all immediate fields live here)
//   kind  - extender control chosen by the decoder
//   imm   - 64-bit extended / shifted immediate; zero for an illegal kind
module imm_extend
  import imm_seq_pkg::*;
(
  input  logic [25:0] instr,
  input  kind_e       kind,
  output logic [63:0] imm
);

  logic [15:0] iw16;

  assign iw16 = instr[20:5];

  always_comb begin
    imm = '0;
    case (kind)
      K_I:  imm = {52'd0, instr[21:10]};
      K_D:  imm = {{55{instr[20]}}, instr[20:12]};
      K_B:  imm = {{38{instr[25]}}, instr[25:0]};
      K_CB: imm = {{45{instr[23]}}, instr[23:5]};
      K_IW: begin
        // hw field picks which 16-bit lane of the result receives imm16
        case (instr[22:21])
          2'd0: imm = {48'd0, iw16};
          2'd1: imm = {32'd0, iw16, 16'd0};
          2'd2: imm = {16'd0, iw16, 32'd0};
          2'd3: imm = {iw16, 48'd0};
          default: imm = '0;
        endcase
      end
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_seq.sv
// imm_seq: decodes an ARMv8 instruction, forms its immediate and queues the
// result in a two-entry in-order output buffer.
//   CLK, Reset_L          - clock, asynchronous active-low reset
//   in_valid/in_ready     - instruction handshake, in_instr is the word
//   out_valid/out_ready   - result handshake
//   out_imm/out_kind/out_err - head entry of the buffer
//   err_cnt               - saturating count of accepted illegal instructions
module imm_seq
  import imm_seq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_imm,
  output logic [2:0]  out_kind,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  kind_e       dec_kind;
  logic [63:0] dec_imm;

  fifo_st_e               state_q, state_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  entry_t [DEPTH-1:0]     mem_q, mem_d;
  logic [7:0]             err_cnt_q, err_cnt_d;

  logic push, pop;
  entry_t head;

  // Decode in priority order; anything unmatched is illegal
  always_comb begin
    dec_kind = K_ILL;
    if (in_instr[31:26] == OP_B)                                   dec_kind = K_B;
    else if (in_instr[31:25] == OP_CB)                             dec_kind = K_CB;
    else if (in_instr[31:21] == OP_LDUR || in_instr[31:21] == OP_STUR) dec_kind = K_D;
    else if (in_instr[31:22] == OP_ADDI || in_instr[31:22] == OP_SUBI) dec_kind = K_I;
    else if (in_instr[31:23] == OP_MOVZ)                           dec_kind = K_IW;
  end

  imm_extend u_ext (
    .instr (in_instr[25:0]),
    .kind  (dec_kind),
    .imm   (dec_imm)
  );

  assign in_ready  = (state_q != S_FULL);
  assign out_valid = (state_q != S_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_d     = mem_q;
    err_cnt_d = err_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q].imm  = dec_imm;
      mem_d[wr_ptr_q].kind = dec_kind;
      mem_d[wr_ptr_q].err  = (dec_kind == K_ILL);
      wr_ptr_d = ~wr_ptr_q;
      if (dec_kind == K_ILL && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    // Simultaneous push and pop leaves occupancy unchanged
    case (state_q)
      S_EMPTY: if (push)         state_d = S_ONE;
      S_ONE:   if (push && !pop) state_d = S_FULL;
               else if (pop && !push) state_d = S_EMPTY;
      S_FULL:  if (pop)          state_d = S_ONE;
      default:                   state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q   <= S_EMPTY;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      mem_q     <= '0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_q     <= mem_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign out_imm  = head.imm;
  assign out_kind = head.kind;
  assign out_err  = head.err;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_imm_seq.sv
module tb_imm_seq;

  logic        CLK, Reset_L;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [31:0] in_instr;
  logic [63:0] out_imm;
  logic [2:0]  out_kind;
  logic [7:0]  err_cnt;

  imm_seq #(.DEPTH(2)) dut (
    .CLK(CLK), .Reset_L(Reset_L),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_kind(out_kind), .out_err(out_err),
    .err_cnt(err_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  kind;
    logic        err;
  } ent_t;

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t mq[$];
  int   m_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint sext(input longint v, input int w);
    longint r;
    r = v;
    if (r >= (longint'(1) << (w - 1))) r = r - (longint'(1) << w);
    return r;
  endfunction

  // Reference decode straight from the instruction-format rules
  function automatic ent_t ref_dec(input logic [31:0] x);
    longint unsigned u;
    ent_t e;
    u = 64'(x);
    e.err = 1'b0;
    if ((u >> 26) == 6'b000101) begin
      e.kind = 3'd2; e.imm = sext(longint'(u % (1 << 26)), 26);
    end else if ((u >> 25) == 7'b1011010) begin
      e.kind = 3'd3; e.imm = sext(longint'((u >> 5) % (1 << 19)), 19);
    end else if ((u >> 21) == 11'b11111000010 || (u >> 21) == 11'b11111000000) begin
      e.kind = 3'd1; e.imm = sext(longint'((u >> 12) % 512), 9);
    end else if ((u >> 22) == 10'b1001000100 || (u >> 22) == 10'b1101000100) begin
      e.kind = 3'd0; e.imm = (u >> 10) % 4096;
    end else if ((u >> 23) == 9'b110100101) begin
      e.kind = 3'd4;
      e.imm = ((u >> 5) % 65536) * (64'd1 << (16 * ((u >> 21) % 4)));
    end else begin
      e.kind = 3'd7; e.imm = 64'd0; e.err = 1'b1;
    end
    return e;
  endfunction

  // Called at a negedge: drive, check outputs vs model, clock once, update model
  task automatic step(input logic v, input logic [31:0] ins, input logic ordy);
    bit pu, po;
    ent_t e;
    in_valid = v; in_instr = ins; out_ready = ordy;
    #1;
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("err_cnt", 64'(err_cnt), 64'(m_err));
    if (mq.size() > 0) begin
      chk("head_imm", out_imm, mq[0].imm);
      chk("head_kind", 64'(out_kind), 64'(mq[0].kind));
      chk("head_err", 64'(out_err), 64'(mq[0].err));
    end
    pu = v && (mq.size() < 2);
    po = ordy && (mq.size() > 0);
    @(posedge CLK);
    if (po) void'(mq.pop_front());
    if (pu) begin
      e = ref_dec(ins);
      mq.push_back(e);
      if (e.err && m_err < 255) m_err++;
    end
    @(negedge CLK);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_imm"}, out_imm, 64'd0);
    chk({tag, "_out_kind"}, 64'(out_kind), 64'd0);
    chk({tag, "_out_err"}, 64'(out_err), 64'd0);
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: return 32'h14000000 | (r & 32'h03FFFFFF);
      1: return 32'hB4000000 | (r & 32'h01FFFFFF);
      2: return 32'hF8400000 | (r & 32'h001FFFFF);
      3: return 32'hF8000000 | (r & 32'h001FFFFF);
      4: return ((r[0] ? 32'h91000000 : 32'hD1000000)) | (r & 32'h003FFFFF);
      5: return 32'hD2800000 | (r & 32'h007FFFFF);
      default: return r;
    endcase
  endfunction

  initial begin
    Reset_L = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b0;
    #1;
    chk_reset_vals("por");
    @(negedge CLK); @(negedge CLK);
    Reset_L = 1'b1;
    @(negedge CLK);

    // ADDI: one-cycle latency
    step(1'b1, 32'h91000C20, 1'b1);
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_imm", out_imm, 64'h3);
    chk("addi_kind", 64'(out_kind), 64'd0);

    // B with all-ones imm26
    step(1'b1, 32'h17FFFFFF, 1'b1);
    chk("b_imm", out_imm, 64'hFFFFFFFFFFFFFFFF);
    chk("b_kind", 64'(out_kind), 64'd2);

    // MOVZ hw=3 imm16=0x1234
    step(1'b1, 32'hD2E24680, 1'b1);
    chk("movz_imm", out_imm, 64'h1234000000000000);
    chk("movz_kind", 64'(out_kind), 64'd4);

    // CB and D examples
    step(1'b1, 32'hB4FFFFE0, 1'b1);
    chk("cb_imm", out_imm, 64'hFFFFFFFFFFFFFFFF);
    step(1'b1, 32'hF8410000, 1'b1);
    chk("d_imm", out_imm, 64'h10);
    step(1'b0, 32'd0, 1'b1);

    // Backpressure: two accepted, third refused even with out_ready=1
    step(1'b1, 32'h91000400, 1'b0);
    step(1'b1, 32'h91000800, 1'b0);
    chk("bp_full", 64'(in_ready), 64'd0);
    step(1'b1, 32'h91000C00, 1'b0);
    step(1'b1, 32'h91000C00, 1'b1);
    chk("bp_second", out_imm, 64'h2);
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Illegal opcode
    step(1'b1, 32'h00000000, 1'b1);
    chk("ill_err", 64'(out_err), 64'd1);
    chk("ill_kind", 64'(out_kind), 64'd7);
    chk("ill_imm", out_imm, 64'd0);
    chk("ill_cnt", 64'(err_cnt), 64'd1);
    for (int i = 0; i < 300; i++) step(1'b1, 32'h00000000, 1'b1);
    chk("ill_sat", 64'(err_cnt), 64'd255);
    step(1'b0, 32'd0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 250; i++)
      step(1'(($urandom % 4) != 0), rand_instr(), 1'(($urandom % 3) != 0));

    // Reset while FULL
    while (mq.size() > 0) step(1'b0, 32'd0, 1'b1);
    step(1'b1, 32'hD2800020, 1'b0);
    step(1'b1, 32'h00000000, 1'b0);
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    Reset_L = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    mq.delete(); m_err = 0;
    in_valid = 1'b0;
    @(negedge CLK);
    Reset_L = 1'b1;
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
